// File: rtl/mmio_bus_bridge_pkg.sv
// Shared definitions for the MMIO bus bridge: FSM state encoding and
// widths that the bridge and its slot decoder agree on.
package mmio_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int SLOT_IDX_W = 4;
  localparam int ERR_CNT_W  = 8;

endpackage

// File: rtl/mmio_bus_bridge_if.sv
// Bus bundles for the bridge: the host-facing request/response port and
// the peripheral-facing slot bus.
interface mmio_host_if #(
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [31:0]   address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          done;
  logic          err;
  logic          busy;

  modport master (
    output req, we, address, data_in,
    input  data_out, done, err, busy
  );

  modport slave (
    input  req, we, address, data_in,
    output data_out, done, err, busy
  );
endinterface

interface mmio_periph_if #(
  parameter int NSLOT    = 4,
  parameter int DW       = 32,
  parameter int SLOT_LSB = 8
);
  logic [NSLOT-1:0]    s_sel;
  logic                s_we;
  logic [SLOT_LSB-1:0] s_addr;
  logic [DW-1:0]       s_wdata;
  logic [NSLOT*DW-1:0] s_rdata;
  logic [NSLOT-1:0]    s_ack;

  modport master (
    output s_sel, s_we, s_addr, s_wdata,
    input  s_rdata, s_ack
  );

  modport slave (
    input  s_sel, s_we, s_addr, s_wdata,
    output s_rdata, s_ack
  );
endinterface

// File: rtl/mmio_slot_decoder.sv
// Combinational slot decode: turns the slot field of a byte address into a
// one-hot select, flagging indices beyond the populated slots.
module mmio_slot_decoder
  import mmio_bus_bridge_pkg::*;
#(
  parameter int NSLOT    = 4,
  parameter int SLOT_LSB = 8
) (
  input  logic [31:0]      address,
  output logic [NSLOT-1:0] sel,
  output logic             invalid
);

  logic [SLOT_IDX_W-1:0] slot;
  logic                  unused_addr;

  assign slot        = address[SLOT_LSB+SLOT_IDX_W-1:SLOT_LSB];
  assign unused_addr = ^{address[31:SLOT_LSB+SLOT_IDX_W], address[SLOT_LSB-1:0]};

  always_comb begin
    invalid = (32'(slot) >= NSLOT);
    sel     = '0;
    for (int k = 0; k < NSLOT; k++) begin
      sel[k] = (slot == SLOT_IDX_W'(k));
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// Single-outstanding MMIO bridge: decodes a host request onto one of NSLOT
// peripheral slots, waits for that slot's ack or a timeout, and reports back.
module mmio_bus_bridge
  import mmio_bus_bridge_pkg::*;
#(
  parameter int NSLOT    = 4,
  parameter int DW       = 32,
  parameter int SLOT_LSB = 8,
  parameter int TMO      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_host_if.slave           host,
  mmio_periph_if.master        periph,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

  state_t              state_q, state_d;
  logic [DW-1:0]       data_out_q, data_out_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [NSLOT-1:0]    s_sel_q, s_sel_d;
  logic                s_we_q, s_we_d;
  logic [SLOT_LSB-1:0] s_addr_q, s_addr_d;
  logic [DW-1:0]       s_wdata_q, s_wdata_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;

  logic [NSLOT-1:0]    dec_sel;
  logic                dec_invalid;
  logic                sel_ack;
  logic [DW-1:0]       sel_rdata;

  mmio_slot_decoder #(
    .NSLOT    (NSLOT),
    .SLOT_LSB (SLOT_LSB)
  ) u_decoder (
    .address (host.address),
    .sel     (dec_sel),
    .invalid (dec_invalid)
  );

  // The registered one-hot select doubles as the slot pointer, so acks and
  // read data from any other slot are masked out here.
  assign sel_ack = |(periph.s_ack & s_sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NSLOT; k++) begin
      if (s_sel_q[k]) begin
        sel_rdata = periph.s_rdata[k*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    data_out_d  = data_out_q;
    done_d      = 1'b0;
    err_d       = err_q;
    busy_d      = busy_q;
    s_sel_d     = s_sel_q;
    s_we_d      = s_we_q;
    s_addr_d    = s_addr_q;
    s_wdata_d   = s_wdata_q;
    err_count_d = err_count_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (host.req) begin
          busy_d    = 1'b1;
          s_we_d    = host.we;
          s_addr_d  = host.address[SLOT_LSB-1:0];
          s_wdata_d = host.data_in;
          if (dec_invalid) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d   = ACCESS;
            s_sel_d   = dec_sel;
            tmo_cnt_d = '0;
          end
        end
      end

      ACCESS: begin
        // Ack is tested before the timeout so a last-cycle ack still succeeds.
        if (sel_ack) begin
          state_d = RESP;
          s_sel_d = '0;
          done_d  = 1'b1;
          err_d   = 1'b0;
          if (!s_we_q) begin
            data_out_d = sel_rdata;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = RESP;
          s_sel_d = '0;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end

      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        if (err_q && (err_count_q != {ERR_CNT_W{1'b1}})) begin
          err_count_d = err_count_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        s_sel_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_out_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      s_sel_q     <= '0;
      s_we_q      <= 1'b0;
      s_addr_q    <= '0;
      s_wdata_q   <= '0;
      err_count_q <= '0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      data_out_q  <= data_out_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      s_sel_q     <= s_sel_d;
      s_we_q      <= s_we_d;
      s_addr_q    <= s_addr_d;
      s_wdata_q   <= s_wdata_d;
      err_count_q <= err_count_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign host.data_out  = data_out_q;
  assign host.done      = done_q;
  assign host.err       = err_q;
  assign host.busy      = busy_q;
  assign periph.s_sel   = s_sel_q;
  assign periph.s_we    = s_we_q;
  assign periph.s_addr  = s_addr_q;
  assign periph.s_wdata = s_wdata_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Self-checking bench for mmio_bus_bridge: directed corner cases plus random
// transactions scored against a transaction-level latency/result model.
module tb_mmio_bus_bridge;

  localparam int NSLOT    = 4;
  localparam int DW       = 32;
  localparam int SLOT_LSB = 8;
  localparam int TMO      = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rdata_mem [NSLOT];
  logic [DW-1:0] model_dout;
  int            model_errs;
  logic [31:0]   rnd_addr;
  int            rnd_slot;

  mmio_host_if #(.DW(DW)) host_bus ();
  mmio_periph_if #(.NSLOT(NSLOT), .DW(DW), .SLOT_LSB(SLOT_LSB)) periph_bus ();

  mmio_bus_bridge #(
    .NSLOT    (NSLOT),
    .DW       (DW),
    .SLOT_LSB (SLOT_LSB),
    .TMO      (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .host      (host_bus),
    .periph    (periph_bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One host transaction. The outcome is predicted from the slot index and
  // the ACCESS cycle in which the target slot starts acking (0 = never).
  task automatic apply_stimulus(input logic we_i, input logic [31:0] addr_i,
                                input logic [DW-1:0] wdata_i, input int ack_at);
    int               slot;
    bit               valid;
    bit               ok;
    int               lat;
    int               sel_cycles;
    logic [NSLOT-1:0] target;
    logic [NSLOT-1:0] exp_sel;
    logic [DW-1:0]    old_dout;
    logic [DW-1:0]    new_dout;
    logic [31:0]      r;
    logic             err_seen;
    logic [7:0]       got_cnt;
    int sel_bad = 0, bus_bad = 0, done_bad = 0, busy_bad = 0, dout_bad = 0;

    slot       = int'(addr_i[SLOT_LSB+3:SLOT_LSB]);
    valid      = (slot < NSLOT);
    ok         = valid && (ack_at >= 1) && (ack_at <= TMO);
    lat        = !valid ? 1 : (ok ? ack_at + 1 : TMO + 1);
    sel_cycles = !valid ? 0 : (ok ? ack_at : TMO);
    target     = '0;
    if (valid) target[slot] = 1'b1;
    old_dout   = model_dout;
    new_dout   = model_dout;
    if (ok && !we_i) new_dout = rdata_mem[slot];
    err_seen   = 1'bx;
    got_cnt    = 8'hxx;

    @(negedge clk);
    for (int k = 0; k < NSLOT; k++) periph_bus.s_rdata[k*DW +: DW] = rdata_mem[k];
    periph_bus.s_ack = '0;
    host_bus.req     = 1'b1;
    host_bus.we      = we_i;
    host_bus.address = addr_i;
    host_bus.data_in = wdata_i;

    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      exp_sel = (c <= sel_cycles) ? target : '0;
      if (periph_bus.s_sel !== exp_sel) sel_bad++;
      if ((periph_bus.s_sel != '0) &&
          ((periph_bus.s_we !== we_i) || (periph_bus.s_addr !== addr_i[SLOT_LSB-1:0]) ||
           (periph_bus.s_wdata !== wdata_i))) bus_bad++;
      if (host_bus.done !== (c == lat)) done_bad++;
      if (host_bus.busy !== (c <= lat)) busy_bad++;
      if (host_bus.data_out !== ((c < lat) ? old_dout : new_dout)) dout_bad++;
      if (c == lat) err_seen = host_bus.err;
      if (c == lat + 1) got_cnt = err_count;

      // Garbage requests while busy must be dropped; none once idle again.
      if (c <= lat) begin
        r                = $urandom;
        host_bus.req     = r[0];
        host_bus.we      = r[1];
        host_bus.address = $urandom;
        host_bus.data_in = $urandom;
      end else begin
        host_bus.req = 1'b0;
      end
      r                = $urandom;
      periph_bus.s_ack = r[NSLOT-1:0] & ~target;
      if (valid && (ack_at >= 1) && (c >= ack_at)) periph_bus.s_ack = periph_bus.s_ack | target;
    end

    model_dout = new_dout;
    if (!ok && (model_errs < 255)) model_errs++;

    check_output("sel_pattern", 64'(sel_bad), 64'd0);
    check_output("slave_bus_stable", 64'(bus_bad), 64'd0);
    check_output("done_timing", 64'(done_bad), 64'd0);
    check_output("busy_window", 64'(busy_bad), 64'd0);
    check_output("data_out", 64'(dout_bad), 64'd0);
    check_output("err_at_done", 64'(err_seen), 64'(!ok));
    check_output("err_count", 64'(got_cnt), 64'(model_errs));
  endtask

  task automatic reset_abort();
    int done_bad = 0;
    @(negedge clk);
    periph_bus.s_ack = '0;
    host_bus.req     = 1'b1;
    host_bus.we      = 1'b1;
    host_bus.address = 32'h0000_00FC;
    host_bus.data_in = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      host_bus.req = 1'b0;
      if (host_bus.done !== 1'b0) done_bad++;
      if (c == 3) reset = 1'b1;
    end
    @(negedge clk);
    check_output("rst_sel", 64'(periph_bus.s_sel), 64'd0);
    check_output("rst_slave_bus",
                 64'({periph_bus.s_we, periph_bus.s_addr, periph_bus.s_wdata}), 64'd0);
    check_output("rst_host_flags", 64'({host_bus.done, host_bus.err, host_bus.busy}), 64'd0);
    check_output("rst_data_out", 64'(host_bus.data_out), 64'd0);
    check_output("rst_err_count", 64'(err_count), 64'd0);
    reset = 1'b0;
    model_dout = '0;
    model_errs = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (host_bus.done !== 1'b0) done_bad++;
    end
    check_output("rst_no_done", 64'(done_bad), 64'd0);
  endtask

  initial begin
    reset               = 1'b1;
    host_bus.req        = 1'b0;
    host_bus.we         = 1'b0;
    host_bus.address    = '0;
    host_bus.data_in    = '0;
    periph_bus.s_ack    = '0;
    periph_bus.s_rdata  = '0;
    model_dout          = '0;
    model_errs          = 0;
    for (int k = 0; k < NSLOT; k++) rdata_mem[k] = $urandom;

    repeat (3) @(negedge clk);
    check_output("reset_sel", 64'(periph_bus.s_sel), 64'd0);
    check_output("reset_flags", 64'({host_bus.done, host_bus.err, host_bus.busy}), 64'd0);
    check_output("reset_data_out", 64'(host_bus.data_out), 64'd0);
    check_output("reset_err_count", 64'(err_count), 64'd0);
    reset = 1'b0;

    rdata_mem[2] = 32'h1234_5678;
    apply_stimulus(1'b0, 32'h0000_0204, 32'h0, 1);
    check_output("zero_wait_read", 64'(host_bus.data_out), 64'h1234_5678);
    apply_stimulus(1'b1, 32'h0000_0110, 32'hA5A5_A5A5, 5);
    apply_stimulus(1'b0, 32'h0000_0000, 32'h0, 0);
    apply_stimulus(1'b0, 32'h0000_0500, 32'h0, 1);
    apply_stimulus(1'b0, 32'h0000_0208, 32'h0, 2);
    apply_stimulus(1'b0, 32'h0000_0304, 32'h0, TMO);
    apply_stimulus(1'b1, 32'h0000_0304, 32'h0BAD_F00D, TMO + 1);
    apply_stimulus(1'b0, 32'h0000_0F00, 32'h0, 1);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NSLOT; k++) rdata_mem[k] = $urandom;
      rnd_slot       = (i % 10 == 9) ? 15 : int'($urandom_range(0, NSLOT + 1));
      rnd_addr       = $urandom;
      rnd_addr[11:8] = 4'(rnd_slot);
      apply_stimulus(1'($urandom_range(0, 1)), rnd_addr, $urandom, int'($urandom_range(0, TMO + 2)));
    end

    reset_abort();

    for (int i = 0; i < 256; i++) begin
      apply_stimulus(1'b0, 32'h0000_0010, 32'h0, 0);
    end
    check_output("err_count_saturated", 64'(err_count), 64'd255);
    apply_stimulus(1'b0, 32'h0000_0100, 32'h0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
